uart_core_param: RTL and testbench

//  Parametrised full-duplex UART with an internal baud-tick generator, configurable data width, parity and stop bits.
//  TX path is double-buffered (holding + shift register), so the host reloads while a frame is in flight.
//  RX path oversamples, rejects start-bit glitches and reports frame, parity and overrun errors.
//  All logic runs on one system clock. Sits between a host register interface and the serial pins.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_tick.sv | 22 ++
 rtl/uart_core_param.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_core_param.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity modes, FSM state
// encodings and the parity helper used by both TX and RX paths.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Parity bit for up to 8 data bits; unused upper bits must be zero.
  function automatic logic parity_bit(input logic [7:0] d, input int unsigned mode);
    return (^d) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-clock pulse every CLK_DIV clocks.
module uart_baud_tick #(
  parameter int unsigned CLK_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         cnt <= '0;
    else if (cnt == CW'(CLK_DIV - 1))  cnt <= '0;
    else                               cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/uart_core_param.sv
// Full-duplex UART: double-buffered transmitter and oversampling receiver
// sharing one baud tick generator on a single system clock.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 27,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_enable,
  input  logic                 ld_tx_data,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_out,
  output logic                 tx_empty,
  output logic                 tx_busy,
  output logic                 tx_over_run,
  input  logic                 rx_enable,
  input  logic                 rx_in,
  input  logic                 uld_rx_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_empty,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_over_run
);

  localparam int unsigned OCW = $clog2(OVERSAMPLE);
  localparam int unsigned BCW = $clog2(DATA_BITS);

  logic tick;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // ---------------- transmitter ----------------
  tx_state_t            tx_state, tx_next;
  logic [OCW-1:0]       tx_tcnt;
  logic [BCW-1:0]       tx_bcnt;
  logic [DATA_BITS-1:0] tx_hold, tx_shift;
  logic                 tx_par;
  logic                 tx_bit_end, tx_go, tx_load;

  assign tx_bit_end = tick && (tx_tcnt == OCW'(OVERSAMPLE - 1));
  assign tx_go      = tx_enable && !tx_empty;
  assign tx_load    = (tx_next == TX_START) && (tx_state != TX_START);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  // Frames start on a tick so every bit, including start, is exactly OVERSAMPLE ticks.
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:   if (tick && tx_go) tx_next = TX_START;
      TX_START:  if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:   if (tx_bit_end && (tx_bcnt == BCW'(DATA_BITS - 1)))
                   tx_next = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
      TX_STOP:   if (tx_bit_end && (tx_bcnt == BCW'(STOP_BITS - 1)))
                   tx_next = tx_go ? TX_START : TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_out  = 1'b1;
    tx_busy = 1'b1;
    case (tx_state)
      TX_IDLE:   tx_busy = 1'b0;
      TX_START:  tx_out  = 1'b0;
      TX_DATA:   tx_out  = tx_shift[0];
      TX_PARITY: tx_out  = tx_par;
      default:   tx_out  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_tcnt     <= '0;
      tx_bcnt     <= '0;
      tx_hold     <= '0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      tx_empty    <= 1'b1;
      tx_over_run <= 1'b0;
    end else begin
      if (tx_state == TX_IDLE)  tx_tcnt <= '0;
      else if (tick)            tx_tcnt <= tx_bit_end ? '0 : tx_tcnt + OCW'(1);

      if (tx_load) begin
        tx_bcnt  <= '0;
        tx_shift <= tx_hold;
        tx_par   <= parity_bit(8'(tx_hold), PARITY);
        tx_empty <= 1'b1;
      end else if (ld_tx_data && tx_empty) begin
        tx_hold     <= tx_data;
        tx_empty    <= 1'b0;
        tx_over_run <= 1'b0;
      end
      if (ld_tx_data && !tx_empty) tx_over_run <= 1'b1;

      if (tx_bit_end && !tx_load) begin
        if (tx_state == TX_DATA) begin
          tx_shift <= tx_shift >> 1;
          tx_bcnt  <= (tx_bcnt == BCW'(DATA_BITS - 1)) ? '0 : tx_bcnt + BCW'(1);
        end else if (tx_state == TX_STOP) begin
          tx_bcnt  <= tx_bcnt + BCW'(1);
        end
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_t            rx_state, rx_next;
  logic                 rx_meta, rx_s;
  logic [OCW-1:0]       rx_tcnt;
  logic [BCW-1:0]       rx_bcnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_bit, rx_stop_bad, rx_done;
  logic                 rx_sample, rx_last_data, rx_last_stop;

  always_comb begin
    rx_sample    = tick && (rx_tcnt == ((rx_state == RX_START) ? OCW'(OVERSAMPLE / 2 - 1)
                                                                : OCW'(OVERSAMPLE - 1)));
    rx_last_data = (rx_bcnt == BCW'(DATA_BITS - 1));
    rx_last_stop = (rx_bcnt == BCW'(STOP_BITS - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    if (!rx_enable) rx_next = RX_IDLE;
    else begin
      case (rx_state)
        RX_IDLE:   if (tick && !rx_s) rx_next = RX_START;
        RX_START:  if (rx_sample) rx_next = rx_s ? RX_IDLE : RX_DATA;
        RX_DATA:   if (rx_sample && rx_last_data)
                     rx_next = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
        RX_PARITY: if (rx_sample) rx_next = RX_STOP;
        RX_STOP:   if (rx_sample && rx_last_stop) rx_next = RX_IDLE;
        default:   rx_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      rx_tcnt       <= '0;
      rx_bcnt       <= '0;
      rx_shift      <= '0;
      rx_par_bit    <= 1'b0;
      rx_stop_bad   <= 1'b0;
      rx_done       <= 1'b0;
      rx_data       <= '0;
      rx_empty      <= 1'b1;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_over_run   <= 1'b0;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_done <= rx_enable && (rx_state == RX_STOP) && rx_sample && rx_last_stop;

      if (!rx_enable || rx_state == RX_IDLE) begin
        rx_tcnt <= '0;
        rx_bcnt <= '0;
      end else if (tick) begin
        rx_tcnt <= rx_sample ? '0 : rx_tcnt + OCW'(1);
      end

      if (rx_enable && rx_sample) begin
        case (rx_state)
          RX_START:  rx_stop_bad <= 1'b0;
          RX_DATA: begin
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            rx_bcnt  <= rx_last_data ? '0 : rx_bcnt + BCW'(1);
          end
          RX_PARITY: rx_par_bit <= rx_s;
          RX_STOP: begin
            rx_stop_bad <= rx_stop_bad | !rx_s;
            rx_bcnt     <= rx_bcnt + BCW'(1);
          end
          default: ;
        endcase
      end

      // A good completion outranks a coincident host read.
      if (rx_done) begin
        rx_frame_err  <= rx_stop_bad;
        rx_parity_err <= (PARITY != PAR_NONE) &&
                         (rx_par_bit != parity_bit(8'(rx_shift), PARITY));
        if (!rx_stop_bad) begin
          rx_data     <= rx_shift;
          rx_empty    <= 1'b0;
          rx_over_run <= !rx_empty && !uld_rx_data;
        end else if (uld_rx_data) begin
          rx_empty <= 1'b1;
        end
      end else if (uld_rx_data) begin
        rx_empty <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: an 8N1 instance with TX looped to its own RX,
// and an 8E1 instance fed by a bench-side serial driver or its own TX.
`timescale 1ns/1ps
module tb_uart_core_param;

  localparam int BIT = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  // instance A: 8N1
  logic       a_tx_en, a_ld, a_tx_out, a_tx_empty, a_tx_busy, a_tx_or;
  logic       a_rx_en, a_uld, a_rx_empty, a_fe, a_pe, a_ror;
  logic [7:0] a_tx_data, a_rx_data;
  // instance B: 8E1
  logic       b_tx_en, b_ld, b_tx_out, b_tx_empty, b_tx_busy, b_tx_or;
  logic       b_rx_en, b_uld, b_rx_empty, b_fe, b_pe, b_ror;
  logic [7:0] b_tx_data, b_rx_data;
  logic       loop_b, drv_rx, b_rx_in;
  assign b_rx_in = loop_b ? b_tx_out : drv_rx;

  uart_core_param #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .tx_enable(a_tx_en), .ld_tx_data(a_ld), .tx_data(a_tx_data),
    .tx_out(a_tx_out), .tx_empty(a_tx_empty), .tx_busy(a_tx_busy), .tx_over_run(a_tx_or),
    .rx_enable(a_rx_en), .rx_in(a_tx_out), .uld_rx_data(a_uld), .rx_data(a_rx_data),
    .rx_empty(a_rx_empty), .rx_frame_err(a_fe), .rx_parity_err(a_pe), .rx_over_run(a_ror));

  uart_core_param #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_b (
    .clk(clk), .reset(reset), .tx_enable(b_tx_en), .ld_tx_data(b_ld), .tx_data(b_tx_data),
    .tx_out(b_tx_out), .tx_empty(b_tx_empty), .tx_busy(b_tx_busy), .tx_over_run(b_tx_or),
    .rx_enable(b_rx_en), .rx_in(b_rx_in), .uld_rx_data(b_uld), .rx_data(b_rx_data),
    .rx_empty(b_rx_empty), .rx_frame_err(b_fe), .rx_parity_err(b_pe), .rx_over_run(b_ror));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Serial frame, bit 0 first on the line; positions past the frame stay 1.
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input int par,
                                             input bit stop0, input bit flip);
    logic [15:0] f;
    int k;
    f = '1;
    f[0] = 1'b0;
    k = 1;
    for (int i = 0; i < 8; i++) begin f[k] = d[i]; k++; end
    if (par != 0) begin
      f[k] = (($countones(d) % 2) == 1) ^ (par == 2) ^ flip;
      k++;
    end
    f[k] = !stop0;
    return f;
  endfunction

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_tx_start(output int t0);
    int n;
    n = 0;
    while (a_tx_out !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    check("tx start seen", 32'(n < 3000), 1);
    t0 = cyc;
  endtask

  // Each bit must hold for exactly BIT clocks: check first and last clock of each.
  task automatic tx_stream_check(input string tag, input logic [63:0] s, input int len, input int t0);
    for (int i = 0; i < len; i++) begin
      wait_cyc(t0 + BIT * i);
      check($sformatf("%s bit%0d head", tag, i), 32'(a_tx_out), 32'(s[i]));
      wait_cyc(t0 + BIT * i + BIT - 1);
      check($sformatf("%s bit%0d tail", tag, i), 32'(a_tx_out), 32'(s[i]));
    end
  endtask

  task automatic pulse_a_ld(input logic [7:0] d);
    a_tx_data = d; a_ld = 1'b1; @(negedge clk); a_ld = 1'b0;
  endtask

  task automatic pulse_b_uld();
    b_uld = 1'b1; @(negedge clk); b_uld = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input bit stop0, input bit flip);
    logic [15:0] f;
    f = frame_bits(d, 1, stop0, flip);
    for (int i = 0; i < 11; i++) begin
      drv_rx = f[i];
      repeat (BIT) @(negedge clk);
    end
    drv_rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  // Reference model of the host-visible RX state of instance B.
  logic [7:0] m_data = 8'h00;
  bit m_empty = 1, m_fe = 0, m_pe = 0, m_or = 0;

  task automatic model_frame(input logic [7:0] d, input bit stop0, input bit flip);
    m_fe = stop0;
    m_pe = flip;
    if (!stop0) begin
      m_or = !m_empty;
      m_empty = 0;
      m_data = d;
    end
  endtask

  task automatic check_rx(input string tag, input logic [7:0] d, input bit e,
                          input bit fe, input bit pe, input bit ov);
    check({tag, " rx_data"}, 32'(b_rx_data), 32'(d));
    check({tag, " rx_empty"}, 32'(b_rx_empty), 32'(e));
    check({tag, " frame_err"}, 32'(b_fe), 32'(fe));
    check({tag, " parity_err"}, 32'(b_pe), 32'(pe));
    check({tag, " over_run"}, 32'(b_ror), 32'(ov));
  endtask

  typedef struct {
    logic [7:0] d;
    bit stop0, flip, uld_first;
    logic [7:0] e_data;
    bit e_empty, e_fe, e_pe, e_or;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [15:0] f1, f2;
    logic [63:0] s;

    vecs[0] = '{8'h81, 1, 0, 1, 8'h5A, 1, 1, 0, 0};
    vecs[1] = '{8'h81, 0, 1, 0, 8'h81, 0, 0, 1, 0};
    vecs[2] = '{8'h3C, 0, 0, 0, 8'h3C, 0, 0, 0, 1};
    vecs[3] = '{8'hC3, 0, 0, 1, 8'hC3, 0, 0, 0, 0};
    vecs[4] = '{8'h00, 1, 1, 0, 8'hC3, 0, 1, 1, 0};
    vecs[5] = '{8'hFF, 0, 0, 0, 8'hFF, 0, 0, 0, 1};

    a_tx_en = 1; a_ld = 0; a_tx_data = '0; a_rx_en = 1; a_uld = 0;
    b_tx_en = 1; b_ld = 0; b_tx_data = '0; b_rx_en = 1; b_uld = 0;
    loop_b = 0; drv_rx = 1;
    repeat (3) @(negedge clk);
    check("reset tx_out", 32'(a_tx_out), 1);
    check("reset tx_empty", 32'(a_tx_empty), 1);
    check("reset tx_busy", 32'(a_tx_busy), 0);
    check("reset tx_over_run", 32'(a_tx_or), 0);
    check_rx("reset", 8'h00, 1, 0, 0, 0);
    reset = 0;
    repeat (5) @(negedge clk);

    // 1) single 8N1 frame
    pulse_a_ld(8'hA5);
    check("A5 tx_empty after load", 32'(a_tx_empty), 0);
    wait_tx_start(t0);
    check("A5 tx_empty at start", 32'(a_tx_empty), 1);
    check("A5 tx_busy at start", 32'(a_tx_busy), 1);
    tx_stream_check("A5", 64'(frame_bits(8'hA5, 0, 0, 0)), 10, t0);
    repeat (4) @(negedge clk);
    check("A5 loop rx_data", 32'(a_rx_data), 32'h A5);
    check("A5 loop rx_empty", 32'(a_rx_empty), 0);
    a_uld = 1; @(negedge clk); a_uld = 0;

    // 2) back-to-back frames and holding-register overrun
    repeat (100) @(negedge clk);
    pulse_a_ld(8'h3C);
    wait_tx_start(t0);
    f1 = frame_bits(8'h3C, 0, 0, 0);
    f2 = frame_bits(8'hC3, 0, 0, 0);
    s = '1;
    s[9:0] = f1[9:0];
    s[19:10] = f2[9:0];
    fork
      tx_stream_check("b2b", s, 20, t0);
      begin
        pulse_a_ld(8'hC3);
        check("b2b accepted load no overrun", 32'(a_tx_or), 0);
        check("b2b holding full", 32'(a_tx_empty), 0);
        pulse_a_ld(8'h00);
        check("b2b overrun set", 32'(a_tx_or), 1);
      end
    join
    wait_cyc(t0 + 20 * BIT);
    check("b2b idle after second frame", 32'(a_tx_out), 1);
    wait_cyc(t0 + 22 * BIT);
    check("b2b idle line", 32'(a_tx_out), 1);
    check("b2b tx_busy idle", 32'(a_tx_busy), 0);
    check("b2b tx_empty idle", 32'(a_tx_empty), 1);
    check("b2b overrun sticky", 32'(a_tx_or), 1);
    check("b2b loop rx_data", 32'(a_rx_data), 32'hC3);
    check("b2b loop rx_over_run", 32'(a_ror), 1);

    // 3) 8E1 loopback through instance B
    loop_b = 1;
    b_tx_data = 8'h5A; b_ld = 1; @(negedge clk); b_ld = 0;
    repeat (13 * BIT) @(negedge clk);
    check_rx("loop5A", 8'h5A, 0, 0, 0, 0);
    model_frame(8'h5A, 0, 0);
    loop_b = 0;
    repeat (BIT) @(negedge clk);

    // 5) directed error vectors
    foreach (vecs[i]) begin
      if (vecs[i].uld_first) begin pulse_b_uld(); m_empty = 1; end
      send_rx(vecs[i].d, vecs[i].stop0, vecs[i].flip);
      model_frame(vecs[i].d, vecs[i].stop0, vecs[i].flip);
      check_rx($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_empty,
               vecs[i].e_fe, vecs[i].e_pe, vecs[i].e_or);
    end

    // 4) short start-bit glitch, then a clean frame to show the FSM is idle
    drv_rx = 0; repeat (20) @(negedge clk); drv_rx = 1;
    repeat (4 * BIT) @(negedge clk);
    check_rx("glitch", m_data, m_empty, m_fe, m_pe, m_or);
    pulse_b_uld(); m_empty = 1;
    send_rx(8'h96, 0, 0);
    model_frame(8'h96, 0, 0);
    check_rx("post-glitch", m_data, m_empty, m_fe, m_pe, m_or);

    // rx_enable dropped mid-frame discards it
    fork
      send_rx(8'h55, 0, 1);
      begin repeat (4 * BIT) @(negedge clk); b_rx_en = 0; end
    join
    b_rx_en = 1;
    repeat (BIT) @(negedge clk);
    check_rx("rx_disable", m_data, m_empty, m_fe, m_pe, m_or);

    // randomized frames against the model
    for (int n = 0; n < 10; n++) begin
      logic [7:0] d;
      int r;
      d = 8'($urandom);
      r = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin pulse_b_uld(); m_empty = 1; end
      send_rx(d, r == 1, r == 2);
      model_frame(d, r == 1, r == 2);
      check_rx($sformatf("rand%0d", n), m_data, m_empty, m_fe, m_pe, m_or);
    end

    // 6) asynchronous reset mid-frame
    pulse_a_ld(8'h0F);
    wait_tx_start(t0);
    drv_rx = 0;
    repeat (100) @(negedge clk);
    check("pre-reset tx_busy", 32'(a_tx_busy), 1);
    reset = 1;
    #1;
    check("async reset tx_out", 32'(a_tx_out), 1);
    check("async reset tx_empty", 32'(a_tx_empty), 1);
    check("async reset tx_busy", 32'(a_tx_busy), 0);
    check("async reset tx_over_run", 32'(a_tx_or), 0);
    check("async reset a rx_data", 32'(a_rx_data), 0);
    check("async reset a rx_empty", 32'(a_rx_empty), 1);
    check("async reset a rx_over_run", 32'(a_ror), 0);
    check_rx("async reset", 8'h00, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
